byte_ram_ctrl: RTL and testbench
================================

Name: byte_ram_ctrl

Overview:
- Access controller directly upstream of the byte RAM.
- Takes single-byte read, write and bit-set/clear requests from the execute stage over a valid/ready handshake. Drives the RAM enable, read/write, address and write-data pins. Returns read data, or the pre-modify byte, with a response pulse.
- Bit operations are a read-modify-write sequence, so the pipeline never has to sequence the RAM itself.

Parameters:
- DATA_W, 8, byte width; matches RAM word width.
- ADDR_W, 8, RAM address width.
- DEPTH, 256, number of implemented RAM locations. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high exactly in IDLE.
- req_op  in  2  00 read, 01 write, 10 bit set/clear (RMW), 11 reserved.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data (op 01).
- req_bit_sel  in  3  bit index (op 10).
- req_bit_val  in  1  new bit value (op 10).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  DATA_W  read byte (op 00 and op 10: original byte); 0 for write and error responses.
- rsp_err  out  1  qualified by rsp_valid; reserved op or (optional) out-of-range address.
- ram_en  out  1  RAM enable.
- ram_rw  out  1  1 = read, 0 = write.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM registered read output. Floats (z) whenever the RAM was clocked with en=0. Only sampled in capture states.

Behaviour:
- Clocking: single clock. Every output is a register. Reset is synchronous and active-low.
- Reset (reset==0 at a posedge):
  - State goes to IDLE. req_ready=1 after reset deasserts.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - ram_en=0, ram_rw=1, ram_addr=0, ram_wdata=0.
- Request handshake: a request is accepted on a posedge (E0) where req_valid & req_ready. The op, addr, wdata, bit_sel and bit_val are latched at E0. Inputs are ignored outside IDLE.
- States: IDLE, RD, RD_CAP, WR, RMW_RD, RMW_CAP, RMW_WR, ERR.
- IDLE:
  - On accept of op 00: ram_en=1, ram_rw=1, ram_addr=addr; go to RD.
  - On accept of op 01: ram_en=1, ram_rw=0, ram_wdata=wdata; go to WR.
  - On accept of op 10: ram_en=1, ram_rw=1; go to RMW_RD.
  - On accept of op 11: go to ERR; no RAM access.
- RD: at E1 the RAM reads. ram_en<=0; go to RD_CAP.
- RD_CAP: at E2, rsp_data<=ram_rdata, rsp_valid<=1; go to IDLE. Read response is visible the cycle after E2 (2 cycles after accept).
- WR: at E1 the RAM writes. ram_en<=0, rsp_valid<=1, rsp_data<=0; go to IDLE.
- RMW_RD: at E1 the RAM reads. ram_en<=0; go to RMW_CAP.
- RMW_CAP: at E2, capture old=ram_rdata. Set ram_wdata<=old with bit[bit_sel] replaced by bit_val; ram_en<=1, ram_rw<=0; go to RMW_WR.
- RMW_WR: at E3 the RAM writes. ram_en<=0, rsp_valid<=1, rsp_data<=old; go to IDLE.
- ERR: rsp_valid<=1, rsp_err<=1, rsp_data<=0; go to IDLE.
- Response pulse: rsp_valid is high exactly one cycle. rsp_err=0 on every non-error response. rsp_data holds its value until the next response.
- Back-to-back: the response cycle is an IDLE cycle, so a new request may be accepted in the same cycle rsp_valid is high. Throughput: read 1 per 3 cycles, write 1 per 2, RMW 1 per 4.
- Bus idle: ram_en=0 in every state other than RD, WR, RMW_RD and RMW_WR. ram_addr holds its last value.
- RMW atomicity: no other request is accepted between the read and the write. An RMW with bit_val equal to the existing bit still performs the write.
- Reset mid-operation: state returns to IDLE with no response. The RAM samples the pre-reset ram_en at the reset edge, so a write already driven in WR or RMW_WR during that cycle still lands in the RAM. No later access is issued.

Optional Feature:
- Macro BYTE_RAM_CTRL_ADDR_CHECK_EN.
- Defined: an accepted request with req_addr >= DEPTH goes to ERR. There is no RAM access, and the rsp_err response arrives 1 cycle after accept.
- Undefined: no comparison is made; address bits pass straight to ram_addr. Only op 11 produces rsp_err.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_valid=1 -> all outputs at reset values, no ram_en pulse. After release, req_ready=1.
- Write then read: write addr 0x12 data 0xA5 -> one ram_en cycle with rw=0, rsp_valid 1 cycle after accept, rsp_data=0. Then read 0x12 -> rsp_data=0xA5 2 cycles after accept, rsp_err=0.
- RMW set/clear: preload 0x12=0x00, then op 10 with bit_sel=3, val=1 -> rsp_data=0x00, memory 0x08. Then bit_sel=3, val=0 -> rsp_data=0x08, memory 0x00.
- Back-to-back: read 0x01 (holds 0x11), then read 0x02 (holds 0x22), req_valid held high -> second accept coincides with the first rsp_valid. Responses 0x11 then 0x22, 3 cycles apart.
- Reserved op 11 -> no ram_en, rsp_valid & rsp_err 1 cycle after accept, rsp_data=0. With BYTE_RAM_CTRL_ADDR_CHECK_EN and DEPTH=16, a read of addr 0x20 behaves the same.
- Reset in RMW_CAP for 0x12=0x0F, bit_sel=7 -> no write issued, memory stays 0x0F, no rsp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/byte_ram_ctrl.sv
// Byte RAM access controller: read, write and bit set/clear (read-modify-write)
// over a valid/ready handshake. Define BYTE_RAM_CTRL_ADDR_CHECK_EN to reject addresses >= DEPTH.
module byte_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_bit_sel,
  input  logic              req_bit_val,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

`ifdef BYTE_RAM_CTRL_ADDR_CHECK_EN
  localparam bit AddrCheck = 1'b1;
`else
  localparam bit AddrCheck = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, RD, RD_CAP, WR, RMW_RD, RMW_CAP, RMW_WR, ERR
  } state_t;

  state_t            state;
  logic [2:0]        bitSel;
  logic              bitVal;
  logic [DATA_W-1:0] oldByte;
  logic [DATA_W-1:0] rmwByte;
  logic              addrBad;

  always_comb begin
    addrBad = 1'b0;
    if (AddrCheck) addrBad = (int'(req_addr) >= DEPTH);
  end

  always_comb begin
    rmwByte         = ram_rdata;
    rmwByte[bitSel] = bitVal;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      ram_en    <= 1'b0;
      ram_rw    <= 1'b1;
      ram_addr  <= '0;
      ram_wdata <= '0;
      bitSel    <= '0;
      bitVal    <= 1'b0;
      oldByte   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_op == 2'b11 || addrBad) begin
              state <= ERR;
            end else begin
              ram_en   <= 1'b1;
              ram_addr <= req_addr;
              case (req_op)
                2'b00: begin
                  ram_rw <= 1'b1;
                  state  <= RD;
                end
                2'b01: begin
                  ram_rw    <= 1'b0;
                  ram_wdata <= req_wdata;
                  state     <= WR;
                end
                default: begin
                  ram_rw <= 1'b1;
                  bitSel <= req_bit_sel;
                  bitVal <= req_bit_val;
                  state  <= RMW_RD;
                end
              endcase
            end
          end
        end
        RD: begin
          ram_en <= 1'b0;
          state  <= RD_CAP;
        end
        RD_CAP: begin
          rsp_data  <= ram_rdata;
          rsp_valid <= 1'b1;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        WR: begin
          ram_en    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        RMW_RD: begin
          ram_en <= 1'b0;
          state  <= RMW_CAP;
        end
        RMW_CAP: begin
          // The modified byte is written back even when the bit already had bitVal.
          oldByte   <= ram_rdata;
          ram_wdata <= rmwByte;
          ram_en    <= 1'b1;
          ram_rw    <= 1'b0;
          state     <= RMW_WR;
        end
        RMW_WR: begin
          ram_en    <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= oldByte;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        ERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ram_en    <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Scoreboard bench for byte_ram_ctrl with a registered-output RAM model that floats when not enabled.
module tb_byte_ram_ctrl;

`ifdef BYTE_RAM_CTRL_ADDR_CHECK_EN
  localparam int TbDepth = 16;
`else
  localparam int TbDepth = 256;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr, req_wdata;
  logic [2:0] req_bit_sel;
  logic       req_bit_val;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_data;
  logic       ram_en, ram_rw;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic       pokeEn = 1'b0;
  logic [7:0] pokeAddr = '0, pokeData = '0;
  logic [7:0] mem [256];

  int cyc = 0, enCount = 0, wrCount = 0;
  int errors = 0, checks = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  byte_ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(TbDepth)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bit_sel(req_bit_sel),
    .req_bit_val(req_bit_val),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en === 1'b1) begin
      enCount <= enCount + 1;
      if (ram_rw === 1'b0) wrCount <= wrCount + 1;
    end
  end

  always @(posedge clk) begin
    if (pokeEn) mem[pokeAddr] <= pokeData;
    if (ram_en === 1'b1) begin
      if (ram_rw === 1'b1) ram_rdata <= mem[ram_addr];
      else begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= 'z;
      end
    end else begin
      ram_rdata <= 'z;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                       input logic [2:0] bs, input logic bv, input logic [7:0] expData,
                       input logic expErr, input int lat, input bit hold, output int acc);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    req_bit_sel = bs; req_bit_val = bv;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
    end
    @(posedge clk); #1;
    acc = cyc;
    sb.push_back('{data: expData, err: expErr, due: acc + lat});
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [7:0] d, output logic e, output int c, output bit to);
    int n;
    n = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 100);
    d = rsp_data; e = rsp_err; c = cyc;
  endtask

  function automatic exp_t pop_exp();
    if (sb.size() == 0) return '{data: 8'hEE, err: 1'b1, due: -1};
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_op = 2'b00; req_addr = 8'h55;
    req_wdata = 8'hFF; req_bit_sel = 3'd0; req_bit_val = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, ram_en, ram_rw, ram_addr, ram_wdata} !==
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b re=%b rd=%h en=%b rw=%b ra=%h wd=%h, expected 0 0 00 0 1 00 00",
               rsp_valid, rsp_err, rsp_data, ram_en, ram_rw, ram_addr, ram_wdata);
    end
    checks++;
    if (enCount !== 0) begin
      errors++;
      $display("FAIL reset_no_access: ram_en cycles=%0d, expected 0", enCount);
    end
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready=%b, expected 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    int acc, c, en0, wr0;
    logic [7:0] d;
    logic e;
    bit to;
    exp_t x;
    en0 = enCount; wr0 = wrCount;
    issue(2'b01, 8'h12, 8'hA5, 3'd0, 1'b0, 8'h00, 1'b0, 1, 1'b0, acc);
    wait_rsp(d, e, c, to);
    x = pop_exp();
    checks++;
    if (to || {e, d} !== {x.err, x.data}) begin
      errors++;
      $display("FAIL write_rsp: timeout=%b err=%b data=%h, expected err=%b data=%h", to, e, d, x.err, x.data);
    end
    checks++;
    if (c !== x.due) begin
      errors++;
      $display("FAIL write_latency: response cycle %0d, expected %0d", c, x.due);
    end
    checks++;
    if ({enCount - en0, wrCount - wr0, mem[8'h12]} !== {32'd1, 32'd1, 8'hA5}) begin
      errors++;
      $display("FAIL write_ram: en=%0d wr=%0d mem=%h, expected 1 1 a5", enCount - en0, wrCount - wr0, mem[8'h12]);
    end
    issue(2'b00, 8'h12, 8'h00, 3'd0, 1'b0, 8'hA5, 1'b0, 2, 1'b0, acc);
    wait_rsp(d, e, c, to);
    x = pop_exp();
    checks++;
    if (to || {e, d} !== {x.err, x.data}) begin
      errors++;
      $display("FAIL read_rsp: timeout=%b err=%b data=%h, expected err=%b data=%h", to, e, d, x.err, x.data);
    end
    checks++;
    if (c !== x.due) begin
      errors++;
      $display("FAIL read_latency: response cycle %0d, expected %0d", c, x.due);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_data} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rsp_hold: valid=%b data=%h, expected 0 a5", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_rmw();
    int acc, c, wr0;
    logic [7:0] d;
    logic e;
    bit to;
    exp_t x;
    logic [7:0] memExp [3];
    logic [2:0] bs [3];
    logic bv [3];
    memExp[0] = 8'h08; memExp[1] = 8'h00; memExp[2] = 8'h00;
    bs[0] = 3'd3; bs[1] = 3'd3; bs[2] = 3'd3;
    bv[0] = 1'b1; bv[1] = 1'b0; bv[2] = 1'b0;
    poke(8'h12, 8'h00);
    for (int i = 0; i < 3; i++) begin
      wr0 = wrCount;
      issue(2'b10, 8'h12, 8'h00, bs[i], bv[i], (i == 0) ? 8'h00 : memExp[i - 1], 1'b0, 3, 1'b0, acc);
      wait_rsp(d, e, c, to);
      x = pop_exp();
      checks++;
      if (to || {e, d} !== {x.err, x.data} || c !== x.due) begin
        errors++;
        $display("FAIL rmw_rsp[%0d]: timeout=%b err=%b data=%h cyc=%0d, expected err=%b data=%h cyc=%0d",
                 i, to, e, d, c, x.err, x.data, x.due);
      end
      checks++;
      if ({mem[8'h12], wrCount - wr0} !== {memExp[i], 32'd1}) begin
        errors++;
        $display("FAIL rmw_mem[%0d]: mem=%h writes=%0d, expected %h 1", i, mem[8'h12], wrCount - wr0, memExp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, c1, c2;
    logic [7:0] d1, d2;
    logic e1, e2;
    bit t1, t2;
    exp_t x1, x2;
    poke(8'h01, 8'h11);
    poke(8'h02, 8'h22);
    fork
      begin
        issue(2'b00, 8'h01, 8'h00, 3'd0, 1'b0, 8'h11, 1'b0, 2, 1'b1, a1);
        issue(2'b00, 8'h02, 8'h00, 3'd0, 1'b0, 8'h22, 1'b0, 2, 1'b0, a2);
      end
      begin
        wait_rsp(d1, e1, c1, t1);
        wait_rsp(d2, e2, c2, t2);
      end
    join
    x1 = pop_exp();
    x2 = pop_exp();
    checks++;
    if (t1 || {e1, d1} !== {x1.err, x1.data} || c1 !== x1.due) begin
      errors++;
      $display("FAIL b2b_first: timeout=%b err=%b data=%h cyc=%0d, expected err=%b data=%h cyc=%0d",
               t1, e1, d1, c1, x1.err, x1.data, x1.due);
    end
    checks++;
    if (t2 || {e2, d2} !== {x2.err, x2.data} || c2 !== x2.due) begin
      errors++;
      $display("FAIL b2b_second: timeout=%b err=%b data=%h cyc=%0d, expected err=%b data=%h cyc=%0d",
               t2, e2, d2, c2, x2.err, x2.data, x2.due);
    end
    checks++;
    if (a2 !== c1 + 1 || c2 - c1 !== 3) begin
      errors++;
      $display("FAIL b2b_timing: accept2=%0d rsp1=%0d spacing=%0d, expected accept2=%0d spacing=3",
               a2, c1, c2 - c1, c1 + 1);
    end
  endtask

  task automatic test_error();
    int acc, c, en0;
    logic [7:0] d;
    logic e;
    bit to;
    exp_t x;
    en0 = enCount;
    issue(2'b11, 8'h34, 8'h77, 3'd0, 1'b0, 8'h00, 1'b1, 1, 1'b0, acc);
    wait_rsp(d, e, c, to);
    x = pop_exp();
    checks++;
    if (to || {e, d} !== {x.err, x.data} || c !== x.due) begin
      errors++;
      $display("FAIL reserved_rsp: timeout=%b err=%b data=%h cyc=%0d, expected err=%b data=%h cyc=%0d",
               to, e, d, c, x.err, x.data, x.due);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_err, enCount - en0} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reserved_after: valid=%b err=%b ram_en cycles=%0d, expected 0 0 0",
               rsp_valid, rsp_err, enCount - en0);
    end
    poke(8'h20, 8'h5C);
    en0 = enCount;
`ifdef BYTE_RAM_CTRL_ADDR_CHECK_EN
    issue(2'b00, 8'h20, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, 1, 1'b0, acc);
`else
    issue(2'b00, 8'h20, 8'h00, 3'd0, 1'b0, 8'h5C, 1'b0, 2, 1'b0, acc);
`endif
    wait_rsp(d, e, c, to);
    x = pop_exp();
    checks++;
    if (to || {e, d} !== {x.err, x.data} || c !== x.due) begin
      errors++;
      $display("FAIL addr20_rsp: timeout=%b err=%b data=%h cyc=%0d, expected err=%b data=%h cyc=%0d",
               to, e, d, c, x.err, x.data, x.due);
    end
    checks++;
`ifdef BYTE_RAM_CTRL_ADDR_CHECK_EN
    if (enCount - en0 !== 0) begin
`else
    if (enCount - en0 !== 1) begin
`endif
      errors++;
      $display("FAIL addr20_access: ram_en cycles=%0d, unexpected count", enCount - en0);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int wr0, seen, n;
    poke(8'h12, 8'h0F);
    wr0 = wrCount;
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 8'h12; req_bit_sel = 3'd7; req_bit_val = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    checks++;
    if ({seen, wrCount - wr0, mem[8'h12]} !== {32'd0, 32'd0, 8'h0F}) begin
      errors++;
      $display("FAIL reset_mid: rsp pulses=%0d writes=%0d mem=%h, expected 0 0 0f", seen, wrCount - wr0, mem[8'h12]);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: req_ready=%b, expected 1", req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rmw();
    test_back_to_back();
    test_error();
    test_reset_mid_rmw();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected responses left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
